apb_console_writer: RTL and testbench

Character-stream front end for the VGA text generator: accepts one byte per handshake, tracks a text cursor and writes printable bytes into the character map through an APB master port wired directly to `apb_vgachargen`. The character map packs four bytes per 32-bit word, and slave writes are full-word. Each printable byte is therefore stored with an APB read-modify-write. Control bytes move the cursor or clear the screen.

---
 rtl/apb_console_writer.sv | 147 ++++++++++++++
 tb/tb_apb_console_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_console_writer.sv
// Byte-stream console front end for the VGA character map.
// Printable bytes are merged into map words by APB read-modify-write.
module apb_console_writer #(
    parameter int          APB_ADDR_WIDTH = 14,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          COLS           = 80,
    parameter int          ROWS           = 30,
    parameter logic [31:0] CLR_WORD       = 32'h2020_2020
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ch_valid_i,
    input  logic [7:0]                ch_data_i,
    output logic                      ch_ready_o,
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i,
    output logic [6:0]                cur_col_o,
    output logic [4:0]                cur_row_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int WA_W  = IDX_W - 2;
    localparam int WORDS = CELLS / 4;

    // Encoding bits [4:2] are {pwrite, penable, psel}, so the APB
    // control outputs come straight from state flops.
    typedef enum logic [4:0] {
        IDLE       = 5'b000_00,
        RD_SETUP   = 5'b001_00,
        RD_ACCESS  = 5'b011_00,
        WR_SETUP   = 5'b101_00,
        WR_ACCESS  = 5'b111_00,
        CLR_SETUP  = 5'b101_01,
        CLR_ACCESS = 5'b111_01
    } state_t;

    state_t                    state;
    logic [7:0]                byte_q;
    logic [1:0]                lane_q;
    logic [WA_W-1:0]           clr_cnt;
    logic [IDX_W-1:0]          idx;
    logic [APB_DATA_WIDTH-1:0] merged;
    logic                      printable;

    function automatic logic [APB_ADDR_WIDTH-1:0] waddr(
        input logic [WA_W-1:0] w
    );
        return APB_ADDR_WIDTH'({w, 2'b00});
    endfunction

    assign idx = IDX_W'(cur_row_o) * IDX_W'(COLS) + IDX_W'(cur_col_o);

    assign printable = (ch_data_i >= 8'h20 && ch_data_i <= 8'h7E) ||
                       ch_data_i[7];

    always_comb begin
        merged = apb_prdata_i;
        merged[{lane_q, 3'b000} +: 8] = byte_q;
    end

    assign apb_psel_o    = state[2];
    assign apb_penable_o = state[3];
    assign apb_pwrite_o  = state[4];
    assign ch_ready_o    = (state == IDLE);
    assign busy_o        = !ch_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            byte_q       <= '0;
            lane_q       <= '0;
            clr_cnt      <= '0;
            apb_paddr_o  <= '0;
            apb_pwdata_o <= '0;
            cur_col_o    <= '0;
            cur_row_o    <= '0;
            err_o        <= 1'b0;
        end else begin
            if (apb_penable_o && apb_pready_i && apb_pslverr_i)
                err_o <= 1'b1;
            unique case (state)
                IDLE: if (ch_valid_i) begin
                    unique case (1'b1)
                        ch_data_i == 8'h0A: begin
                            cur_col_o <= '0;
                            cur_row_o <= (cur_row_o == 5'(ROWS - 1)) ?
                                         '0 : cur_row_o + 5'd1;
                        end
                        ch_data_i == 8'h0D: cur_col_o <= '0;
                        ch_data_i == 8'h0C: begin
                            clr_cnt      <= '0;
                            apb_paddr_o  <= '0;
                            apb_pwdata_o <= APB_DATA_WIDTH'(CLR_WORD);
                            state        <= CLR_SETUP;
                        end
                        printable: begin
                            byte_q      <= ch_data_i;
                            lane_q      <= idx[1:0];
                            apb_paddr_o <= waddr(idx[IDX_W-1:2]);
                            state       <= RD_SETUP;
                        end
                        default: ;
                    endcase
                end
                RD_SETUP: state <= RD_ACCESS;
                RD_ACCESS: if (apb_pready_i) begin
                    apb_pwdata_o <= merged;
                    state        <= WR_SETUP;
                end
                WR_SETUP: state <= WR_ACCESS;
                WR_ACCESS: if (apb_pready_i) begin
                    if (cur_col_o == 7'(COLS - 1)) begin
                        cur_col_o <= '0;
                        cur_row_o <= (cur_row_o == 5'(ROWS - 1)) ?
                                     '0 : cur_row_o + 5'd1;
                    end else begin
                        cur_col_o <= cur_col_o + 7'd1;
                    end
                    state <= IDLE;
                end
                CLR_SETUP: state <= CLR_ACCESS;
                CLR_ACCESS: if (apb_pready_i) begin
                    if (clr_cnt == WA_W'(WORDS - 1)) begin
                        cur_col_o <= '0;
                        cur_row_o <= '0;
                        state     <= IDLE;
                    end else begin
                        clr_cnt     <= clr_cnt + 1'b1;
                        apb_paddr_o <= waddr(clr_cnt + 1'b1);
                        state       <= CLR_SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_console_writer.sv
// Directed bench for apb_console_writer against a 3-cycle APB
// memory slave model.
module tb_apb_console_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic [13:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    apb_console_writer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_valid_i   (ch_valid),
        .ch_data_i    (ch_data),
        .ch_ready_o   (ch_ready),
        .apb_paddr_o  (paddr),
        .apb_pwdata_o (pwdata),
        .apb_pwrite_o (pwrite),
        .apb_psel_o   (psel),
        .apb_penable_o(penable),
        .apb_prdata_i (prdata),
        .apb_pready_i (pready),
        .apb_pslverr_i(pslverr),
        .cur_col_o    (cur_col),
        .cur_row_o    (cur_row),
        .busy_o       (busy),
        .err_o        (err)
    );

    // Slave model: pready in the third access cycle.
    logic [31:0] mem [0:1023];
    int          acnt = 0;
    logic        slverr_rd = 1'b0;
    int          psel_cycles = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [13:0] last_rd_addr = '0;
    logic [13:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        clr_mode = 1'b0;
    int          clr_next = 0;
    int          clr_bad = 0;

    assign pready  = psel & penable & (acnt == 2);
    assign prdata  = mem[paddr[11:2]];
    assign pslverr = slverr_rd & pready & !pwrite;

    always @(posedge clk) begin
        if (psel && penable && !pready) acnt <= acnt + 1;
        else acnt <= 0;
        if (psel) psel_cycles <= psel_cycles + 1;
        if (psel && penable && pready) begin
            if (pwrite) begin
                mem[paddr[11:2]] <= pwdata;
                n_wr         <= n_wr + 1;
                last_wr_addr <= paddr;
                last_wr_data <= pwdata;
                if (clr_mode) begin
                    if (pwdata !== 32'h2020_2020 ||
                        paddr !== 14'(clr_next * 4))
                        clr_bad <= clr_bad + 1;
                    clr_next <= clr_next + 1;
                end
            end else begin
                n_rd         <= n_rd + 1;
                last_rd_addr <= paddr;
            end
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cur(input string tag, input int col, input int row);
        chk({tag, "_col"}, 32'(cur_col), 32'(col));
        chk({tag, "_row"}, 32'(cur_row), 32'(row));
    endtask

    // lat = cycle number (accept edge starts cycle 1) where ready is seen
    task automatic send(input logic [7:0] b, output int lat);
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = b;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        lat = 1;
        while (!ch_ready && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ch_ready) begin
            nchk++;
            nerr++;
            $error("FAIL timeout: ready still %b after %0d cycles",
                   ch_ready, lat);
        end
    endtask

    initial begin
        int lat;
        int pc;
        int nw;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst      = 1'b1;
        ch_valid = 1'b0;
        ch_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_paddr", 32'(paddr), 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ch_ready), 1);
        chk("rst_err", 32'(err), 0);
        chk_cur("rst", 0, 0);

        send(8'h41, lat);
        chk("a_lat", 32'(lat), 9);
        chk("a_nrd", 32'(n_rd), 1);
        chk("a_rdaddr", 32'(last_rd_addr), 0);
        chk("a_wraddr", 32'(last_wr_addr), 0);
        chk("a_wrdata", last_wr_data, 32'h0000_0041);
        chk_cur("a", 1, 0);

        send(8'h42, lat);
        chk("b_wraddr", 32'(last_wr_addr), 0);
        send(8'h43, lat);
        chk("c_wraddr", 32'(last_wr_addr), 0);
        send(8'h44, lat);
        chk("d_wraddr", 32'(last_wr_addr), 0);
        chk("abcd_word", mem[0], 32'h4443_4241);
        send(8'h45, lat);
        chk("e_wraddr", 32'(last_wr_addr), 4);
        chk("e_word", mem[1], 32'h0000_0045);
        chk_cur("e", 5, 0);

        pc = psel_cycles;
        send(8'h0D, lat);
        chk("cr_lat", 32'(lat), 1);
        chk("cr_noapb", 32'(psel_cycles), 32'(pc));
        chk_cur("cr", 0, 0);
        for (int i = 0; i < 79; i++) send(8'h61, lat);
        chk_cur("c79", 79, 0);
        send(8'h62, lat);
        chk_cur("c80", 0, 1);
        send(8'h63, lat);
        chk("w81_addr", 32'(last_wr_addr), 80);
        chk("w81_data", last_wr_data, 32'h0000_0063);
        chk_cur("c81", 1, 1);

        send(8'h0D, lat);
        for (int i = 0; i < 28; i++) send(8'h0A, lat);
        chk_cur("lf28", 0, 29);
        for (int i = 0; i < 79; i++) send(8'h78, lat);
        chk_cur("end79", 79, 29);
        send(8'h79, lat);
        chk("last_addr", 32'(last_wr_addr), 2396);
        chk("last_lane3", 32'(last_wr_data[31:24]), 32'h79);
        chk_cur("wrap00", 0, 0);

        for (int i = 0; i < 29; i++) send(8'h0A, lat);
        send(8'h71, lat);
        chk_cur("pre_bb", 1, 29);
        pc = psel_cycles;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h0D;
        chk("bb_rdy0", 32'(ch_ready), 1);
        @(posedge clk);
        #1;
        chk_cur("bb_cr", 0, 29);
        @(negedge clk);
        ch_data = 8'h0A;
        chk("bb_rdy1", 32'(ch_ready), 1);
        @(posedge clk);
        #1;
        chk_cur("bb_lf", 0, 0);
        @(negedge clk);
        ch_data = 8'h07;
        chk("bb_rdy2", 32'(ch_ready), 1);
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        chk_cur("bb_bel", 0, 0);
        chk("bb_rdy3", 32'(ch_ready), 1);
        chk("bb_noapb", 32'(psel_cycles), 32'(pc));

        slverr_rd = 1'b1;
        nw = n_wr;
        send(8'h45, lat);
        slverr_rd = 1'b0;
        chk("err_set", 32'(err), 1);
        chk("err_wr", 32'(n_wr), 32'(nw + 1));
        chk("err_lat", 32'(lat), 9);
        send(8'h46, lat);
        chk("err_sticky", 32'(err), 1);
        chk_cur("err", 2, 0);

        clr_mode = 1'b1;
        clr_next = 0;
        nw = n_wr;
        send(8'h0C, lat);
        clr_mode = 1'b0;
        chk("clr_busy", 32'(lat - 1), 2400);
        chk("clr_nwr", 32'(n_wr - nw), 600);
        chk("clr_seq", 32'(clr_next), 600);
        chk("clr_bad", 32'(clr_bad), 0);
        chk("clr_last", mem[599], 32'h2020_2020);
        chk_cur("clr", 0, 0);

        send(8'h0A, lat);
        nw = n_wr;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h5A;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        lat = 0;
        while (!(psel && penable && pwrite) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mid_wracc", 32'(psel && penable && pwrite), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_psel", 32'(psel), 0);
        chk("mid_penable", 32'(penable), 0);
        chk("mid_err", 32'(err), 0);
        chk("mid_nowr", 32'(n_wr), 32'(nw));
        chk_cur("mid", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_ready", 32'(ch_ready), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
